// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a small transmit FIFO in front of the shifter.
// Frames go out LSB-first, back-to-back, with optional parity and one or two stop bits.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | line idle high, waiting for the FIFO to become non-empty
// ST_START | start bit (low) for CLKS_PER_BIT cycles
// ST_DATA  | DATA_W data bits, LSB first, one per CLKS_PER_BIT cycles
// ST_PARITY| single parity bit captured when the word was popped
// ST_STOP  | STOP_BITS stop bits high; reloads directly into ST_START
module uart_tx_param #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_W       = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] tx_DATA,
   output logic              tx_ready,
   output logic              txd,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              tx_overflow
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = AW + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              full;
   logic              empty;
   logic              wr_en;
   logic              pop;
   logic [DATA_W-1:0] head;
   logic              overflow_q;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              txd_q, txd_d;
   logic              done_q, done_d;
   logic              baud_last;
   logic              load;

   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign wr_en = tx_start & ~full;
   assign head  = mem[rd_ptr_q];
   assign pop   = load;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= tx_DATA;
      end
   end

   // A simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= tx_start & full;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         par_q   <= 1'b0;
         baud_q  <= '0;
         bit_q   <= '0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      par_d   = par_q;
      bit_d   = bit_q;
      txd_d   = txd_q;
      done_d  = 1'b0;
      load    = 1'b0;
      baud_d  = (state_q == ST_IDLE || baud_last) ? '0 : baud_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               load = 1'b1;
            end
         end
         ST_START: begin
            if (baud_last) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (baud_last) begin
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = ST_PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_last) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            // Registered one cycle early so the pulse covers the final stop-bit cycle.
            if (bit_q == STOP_LAST && baud_q == BAUD_PRE) begin
               done_d = 1'b1;
            end
            if (baud_last) begin
               if (bit_q == STOP_LAST) begin
                  if (!empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      if (load) begin
         state_d = ST_START;
         shift_d = head;
         par_d   = (PARITY == 1) ? ~(^head) : ^head;
         bit_d   = '0;
         baud_d  = '0;
         txd_d   = 1'b0;
      end
   end

   assign txd         = txd_q;
   assign tx_done     = done_q;
   assign tx_overflow = overflow_q;
   assign tx_busy     = (state_q != ST_IDLE);
   assign tx_ready    = ~full;

endmodule
